// File: rtl/adsr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adsr_pkg
//  Description : Shared definitions for the ADSR envelope generator: the
//                3-bit stage encoding and the full-scale level helper.
//  Revision    : 1.0  initial release
// ============================================================================
package adsr_pkg;

   // Stage codes are visible on the stage output, so the values are fixed.
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ATTACK  = 3'd1,
      ST_DECAY   = 3'd2,
      ST_SUSTAIN = 3'd3,
      ST_RELEASE = 3'd4
   } adsr_stage_t;

   // Full-scale level for a w-bit envelope: 2^w - 1.
   function automatic int unsigned adsr_max_level(input int unsigned w);
      return (32'd1 << w) - 32'd1;
   endfunction

endpackage : adsr_pkg
`default_nettype wire

// File: rtl/adsr_step_timer.sv
`default_nettype none
// ============================================================================
//  Module      : adsr_step_timer
//  Description : Step timebase for the envelope. A prescaler divides clk by
//                PRESCALE; a rate counter counts prescaler ticks. A step
//                fires on a terminal tick once the rate counter has reached
//                the (live) rate, giving one step every PRESCALE*(rate+1)
//                clocks after the last clear.
//  Ports       : clk, rst_n (sync, active-low)
//                clear  - restart both counters (stage entry)
//                rate   - active stage rate
//                step   - one-cycle step strobe (combinational)
//  Revision    : 1.0  initial release
// ============================================================================
module adsr_step_timer #(
   parameter int RW       = 8,
   parameter int PRESCALE = 256
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clear,
   input  logic [RW-1:0] rate,
   output logic          step
);

   // A one-clock prescaler still needs a 1-bit counter that simply stays 0.
   localparam int unsigned c_pw = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [c_pw-1:0] c_psc_tc  = c_pw'(PRESCALE - 1);
   localparam logic [c_pw-1:0] c_psc_one = c_pw'(1);
   localparam logic [RW-1:0]   c_rate_one = RW'(1);

   logic [c_pw-1:0] r_psc;
   logic [RW-1:0]   r_rate_cnt;
   logic            w_tc;
   logic            w_rate_hit;

   assign w_tc       = (r_psc == c_psc_tc);
   // >= rather than == so a rate lowered mid-interval fires at once.
   assign w_rate_hit = (r_rate_cnt >= rate);
   assign step       = w_tc && w_rate_hit;

   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         r_psc      <= '0;
         r_rate_cnt <= '0;
      end else if (w_tc) begin
         r_psc      <= '0;
         r_rate_cnt <= w_rate_hit ? '0 : r_rate_cnt + c_rate_one;
      end else begin
         r_psc      <= r_psc + c_psc_one;
      end
   end

endmodule : adsr_step_timer
`default_nettype wire

// File: rtl/adsr_envelope.sv
`default_nettype none
// ============================================================================
//  Module      : adsr_envelope
//  Description : Gate-driven ADSR envelope generator. Level ramps up in
//                ATTACK, down to the sustain level in DECAY, follows the
//                sustain input in SUSTAIN and falls to zero in RELEASE.
//                Optional retrigger is enabled by defining ADSR_RETRIG_EN;
//                otherwise trig is ignored.
//  Ports       : clk, rst_n (sync, active-low)
//                gate         - note held (level-sensitive)
//                trig         - one-cycle retrigger pulse
//                attack/decay - per-stage step rates
//                release_rate - release step rate ("release" is a reserved
//                               word, hence the longer port name)
//                sustain      - sustain level
//                level        - registered envelope level
//                stage        - current stage code
//                busy         - stage != IDLE
//                done         - one-cycle pulse as release reaches zero
//  Revision    : 1.0  initial release
// ============================================================================
module adsr_envelope
   import adsr_pkg::*;
#(
   parameter int W        = 8,
   parameter int RW       = 8,
   parameter int PRESCALE = 256
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          gate,
   input  logic          trig,
   input  logic [RW-1:0] attack,
   input  logic [RW-1:0] decay,
   input  logic [RW-1:0] release_rate,
   input  logic [W-1:0]  sustain,
   output logic [W-1:0]  level,
   output logic [2:0]    stage,
   output logic          busy,
   output logic          done
);

   localparam logic [W-1:0] c_max = W'(adsr_max_level(W));
   localparam logic [W-1:0] c_one = W'(1);

   adsr_stage_t     r_state, w_state_nxt;
   logic [W-1:0]    r_level, w_level_nxt;
   logic            r_done,  w_done_nxt;
   logic            w_clear;
   logic            w_step;
   logic            w_retrig;
   logic [RW-1:0]   w_rate;

`ifdef ADSR_RETRIG_EN
   assign w_retrig = trig;
`else
   logic w_trig_unused;
   assign w_trig_unused = trig;
   assign w_retrig      = 1'b0;
`endif

   // Sustain tracking steps at the decay rate.
   always_comb begin
      w_rate = decay;
      case (r_state)
         ST_ATTACK:  w_rate = attack;
         ST_RELEASE: w_rate = release_rate;
         default:    w_rate = decay;
      endcase
   end

   adsr_step_timer #(
      .RW       (RW),
      .PRESCALE (PRESCALE)
   ) u_step_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (w_clear),
      .rate  (w_rate),
      .step  (w_step)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_level <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_level <= w_level_nxt;
         r_done  <= w_done_nxt;
      end
   end

   // Within a cycle: gate fall beats retrigger, which beats a step. A step
   // that lands on a stage target changes stage on the same edge.
   always_comb begin
      w_state_nxt = r_state;
      w_level_nxt = r_level;
      w_done_nxt  = 1'b0;
      w_clear     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_level_nxt = '0;
            if (gate) w_state_nxt = ST_ATTACK;
         end
         ST_ATTACK: begin
            if (!gate) begin
               w_state_nxt = ST_RELEASE;
            end else if (w_retrig) begin
               w_clear = 1'b1;
            end else if (r_level == c_max) begin
               w_state_nxt = ST_DECAY;
            end else if (w_step) begin
               w_level_nxt = r_level + c_one;
               if (w_level_nxt == c_max) w_state_nxt = ST_DECAY;
            end
         end
         ST_DECAY: begin
            if (!gate) begin
               w_state_nxt = ST_RELEASE;
            end else if (w_retrig) begin
               w_state_nxt = ST_ATTACK;
            end else if (r_level <= sustain) begin
               w_state_nxt = ST_SUSTAIN;
            end else if (w_step) begin
               w_level_nxt = r_level - c_one;
               if (w_level_nxt == sustain) w_state_nxt = ST_SUSTAIN;
            end
         end
         ST_SUSTAIN: begin
            if (!gate) begin
               w_state_nxt = ST_RELEASE;
            end else if (w_retrig) begin
               w_state_nxt = ST_ATTACK;
            end else if (w_step) begin
               if (r_level < sustain)      w_level_nxt = r_level + c_one;
               else if (r_level > sustain) w_level_nxt = r_level - c_one;
            end
         end
         ST_RELEASE: begin
            if (gate) begin
               w_state_nxt = ST_ATTACK;
            end else if (r_level == '0) begin
               w_state_nxt = ST_IDLE;
               w_done_nxt  = 1'b1;
            end else if (w_step) begin
               w_level_nxt = r_level - c_one;
               if (w_level_nxt == '0) begin
                  w_state_nxt = ST_IDLE;
                  w_done_nxt  = 1'b1;
               end
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_level_nxt = '0;
         end
      endcase
      // Every stage entry restarts the step timebase.
      if (w_state_nxt != r_state) w_clear = 1'b1;
   end

   assign level = r_level;
   assign stage = r_state;
   assign busy  = (r_state != ST_IDLE);
   assign done  = r_done;

endmodule : adsr_envelope
`default_nettype wire

// File: tb/tb_adsr_envelope.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adsr_envelope
//  Description : Self-checking bench for adsr_envelope (W=8, RW=8,
//                PRESCALE=1). Expected values are hand-derived; with
//                ADSR_RETRIG_EN defined the retrigger rows expect a restart.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_adsr_envelope;

   localparam int W        = 8;
   localparam int RW       = 8;
   localparam int PRESCALE = 1;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_ATT  = 3'd1;
   localparam logic [2:0] S_DEC  = 3'd2;
   localparam logic [2:0] S_SUS  = 3'd3;
   localparam logic [2:0] S_REL  = 3'd4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          gate;
   logic          trig;
   logic [RW-1:0] attack;
   logic [RW-1:0] decay;
   logic [RW-1:0] release_rate;
   logic [W-1:0]  sustain;
   logic [W-1:0]  level;
   logic [2:0]    stage;
   logic          busy;
   logic          done;

   adsr_envelope #(
      .W        (W),
      .RW       (RW),
      .PRESCALE (PRESCALE)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .gate         (gate),
      .trig         (trig),
      .attack       (attack),
      .decay        (decay),
      .release_rate (release_rate),
      .sustain      (sustain),
      .level        (level),
      .stage        (stage),
      .busy         (busy),
      .done         (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic         g;
      logic         t;
      logic [W-1:0] sus;
      int           n;
      int           lvl;
      int           stg;
      int           dn;
      string        name;
   } vec_t;

   typedef struct {
      int    lvl;
      int    stg;
      int    dn;
      string name;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   n_cmp    = 0;
   int   n_bad    = 0;
   int   done_cnt = 0;

   always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

   task automatic chk(input string nm, input int act, input int exp_v);
      n_cmp++;
      if (act != exp_v) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
      end
   endtask

   // Advance n rising edges, then settle on the following falling edge.
   task automatic run(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   // Drive inputs, log the expectation, run, then compare against the oldest
   // logged expectation.
   task automatic apply(input logic g, input logic t, input logic [W-1:0] sus,
                        input int n, input int lvl, input int stg, input int dn,
                        input string nm);
      exp_t e;
      gate    = g;
      trig    = t;
      sustain = sus;
      sb.push_back('{lvl, stg, dn, nm});
      run(n);
      trig = 1'b0;
      e = sb.pop_front();
      chk({e.name, ".level"}, int'(level), e.lvl);
      chk({e.name, ".stage"}, int'(stage), e.stg);
      chk({e.name, ".busy"},  int'(busy),  (e.stg != 0) ? 1 : 0);
      chk({e.name, ".done"},  int'(done),  e.dn);
   endtask

   task automatic add(input logic g, input logic t, input int sus, input int n,
                      input int lvl, input int stg, input int dn, input string nm);
      vecs.push_back('{g, t, W'(sus), n, lvl, stg, dn, nm});
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Full ADSR, sustain tracking, retrigger and release from sustain.
      add(0, 0, 128,   3,   0, S_IDLE, 0, "idle_hold");
      add(1, 0, 128,   1,   0, S_ATT,  0, "att_entry");
      add(1, 0, 128, 100, 100, S_ATT,  0, "att_100");
      add(1, 0, 128, 155, 255, S_DEC,  0, "att_max");
      add(1, 0, 128,   1, 254, S_DEC,  0, "dec_first");
      add(1, 0, 128, 126, 128, S_SUS,  0, "dec_to_sus");
      add(1, 0, 128,   5, 128, S_SUS,  0, "sus_hold");
      add(1, 0, 130,   1, 129, S_SUS,  0, "track_up1");
      add(1, 0, 130,   1, 130, S_SUS,  0, "track_up2");
      add(1, 0, 130,   3, 130, S_SUS,  0, "track_hold");
      add(1, 0, 128,   2, 128, S_SUS,  0, "track_down");
`ifdef ADSR_RETRIG_EN
      add(1, 1, 128,   1, 128, S_ATT,  0, "retrig");
      add(1, 0, 128, 127, 255, S_DEC,  0, "retrig_max");
`else
      add(1, 1, 128,   1, 128, S_SUS,  0, "retrig");
      add(1, 0, 128, 127, 128, S_SUS,  0, "retrig_max");
`endif
      add(1, 0, 128, 127, 128, S_SUS,  0, "resettle");
      add(0, 0, 128,   1, 128, S_REL,  0, "rel_entry");
      add(0, 0, 128,   1, 128, S_REL,  0, "rel_wait");
      add(0, 0, 128,   1, 127, S_REL,  0, "rel_step1");
      add(0, 0, 128, 253,   1, S_REL,  0, "rel_last");
      add(0, 0, 128,   1,   0, S_IDLE, 1, "rel_done");
      add(0, 0, 128,   1,   0, S_IDLE, 0, "done_pulse");

      rst_n        = 1'b0;
      gate         = 1'b0;
      trig         = 1'b0;
      attack       = '0;
      decay        = '0;
      release_rate = RW'(1);
      sustain      = W'(128);
      run(2);
      chk("reset.level", int'(level), 0);
      chk("reset.stage", int'(stage), 0);
      chk("reset.busy",  int'(busy),  0);
      chk("reset.done",  int'(done),  0);
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++)
         apply(vecs[i].g, vecs[i].t, vecs[i].sus, vecs[i].n,
               vecs[i].lvl, vecs[i].stg, vecs[i].dn, vecs[i].name);
      chk("done_count_release", done_cnt, 1);

      // Early release at attack level 100, then gate back on in release.
      apply(1, 0, 128, 101, 100, S_ATT, 0, "early_att");
      apply(0, 0, 128,   1, 100, S_REL, 0, "early_rel");
      apply(0, 0, 128,   2,  99, S_REL, 0, "early_dec");
      apply(1, 0, 128,   1,  99, S_ATT, 0, "rel_to_att");
      apply(1, 0, 128,   1, 100, S_ATT, 0, "reatt_step");

      // Reset mid-ramp at level 77: immediate abort, no done pulse.
      rst_n = 1'b0;
      apply(0, 0, 128,  1,  0, S_IDLE, 0, "reset_clean");
      rst_n = 1'b1;
      apply(1, 0, 128, 78, 77, S_ATT,  0, "ramp_77");
      rst_n = 1'b0;
      apply(1, 0, 128,  2,  0, S_IDLE, 0, "reset_mid");
      rst_n = 1'b1;
      apply(0, 0, 128,  1,  0, S_IDLE, 0, "post_reset");
      chk("done_count_reset", done_cnt, 1);

      // Release entered at level 0: IDLE next cycle with done.
      apply(1, 0, 128, 1, 0, S_ATT,  0, "zero_att");
      apply(0, 0, 128, 1, 0, S_REL,  0, "zero_rel");
      apply(0, 0, 128, 1, 0, S_IDLE, 1, "zero_done");
      apply(0, 0, 128, 1, 0, S_IDLE, 0, "zero_idle");
      chk("done_count_zero", done_cnt, 2);

      // Slower rate: first step exactly PRESCALE*(rate+1) = 3 cycles in.
      attack = RW'(2);
      apply(1, 0, 128, 1, 0, S_ATT, 0, "slow_entry");
      apply(1, 0, 128, 2, 0, S_ATT, 0, "slow_wait");
      apply(1, 0, 128, 1, 1, S_ATT, 0, "slow_step1");
      apply(1, 0, 128, 3, 2, S_ATT, 0, "slow_step2");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_adsr_envelope
`default_nettype wire
